// File: rtl/mul_issue_stage.sv
// Two-stage valid/ready wrapper around an external unsigned 32x32->64 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// S1 registers operand magnitudes that feed the multiplier; S2 sign-corrects the product and selects the result half.
module mul_issue_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    logic             s1_valid;
    logic             s1_neg;
    op_e              s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;

    logic             s2_adv;
    logic             s1_adv;
    logic             take;
    logic             sa;
    logic             sb;
    logic [63:0]      p;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign take      = in_valid && in_ready;
    assign out_valid = s2_valid;

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
    assign sa = in_a[31] && (op_e'(in_op) == OP_MULH || op_e'(in_op) == OP_MULHSU);
    assign sb = in_b[31] && (op_e'(in_op) == OP_MULH);

    // Magnitude product back to two's complement; carry out of bit 63 is dropped.
    assign p = s1_neg ? (~mul_p + 64'd1) : mul_p;

    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_op    <= OP_MUL;
            s1_tag   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= take;
            if (take) begin
                s1_neg <= sa ^ sb;
                s1_op  <= op_e'(in_op);
                s1_tag <= in_tag;
                mul_a  <= sa ? (~in_a + 32'd1) : in_a;
                mul_b  <= sb ? (~in_b + 32'd1) : in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= (s1_op == OP_MUL) ? p[31:0] : p[63:32];
                out_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_stage.sv
// Scoreboard bench for mul_issue_stage: expected results are queued at input handshake and matched at output handshake.
// A behavioural multiplier drives mul_p; the reference model works on sign-extended 64-bit operands.
module tb_mul_issue_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t             sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    logic [31:0]      drv_exp;
    bit               check_lat = 1'b0;
    bit               rnd_done;

    mul_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] prod;
        ea   = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb   = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        prod = ea * eb;
        return (op == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    // Monitor on the falling edge: handshakes, scoreboard, and hold stability.
    logic             prev_hold = 1'b0;
    logic [31:0]      held_res;
    logic [TAG_W-1:0] held_tag;
    logic             prev_s1hold = 1'b0;
    logic [31:0]      held_a;
    logic [31:0]      held_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_hold   = 1'b0;
            prev_s1hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'(out_result), 64'(held_res));
                check("hold_tag", 64'(out_tag), 64'(held_tag));
            end
            if (prev_s1hold) begin
                check("hold_mul_a", 64'(mul_a), 64'(held_a));
                check("hold_mul_b", 64'(mul_b), 64'(held_b));
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_tag", 64'(out_tag), 64'hdead);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("result", 64'(out_result), 64'(e.res));
                        check("tag", 64'(out_tag), 64'(e.tag));
                        if (check_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_t n;
                    n.res = drv_exp;
                    n.tag = in_tag;
                    n.cyc = cyc;
                    sb_q.push_back(n);
                end
            end
            prev_hold   = out_valid && !out_ready && !flush;
            held_res    = out_result;
            held_tag    = out_tag;
            prev_s1hold = !in_ready && !flush;
            held_a      = mul_a;
            held_b      = mul_b;
        end
    end

    // Drives one op starting just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        drv_exp  = exp;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #2;
            done = (sb_q.size() == 0) && !out_valid;
        end
        if (!done) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        drv_exp   = '0;
        out_ready = 1'b1;

        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        #14 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed corner vectors, one at a time, with latency checking.
        check_lat = 1'b1;
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE); wait_drain();
        send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000); wait_drain();
        send(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h0000_0000); wait_drain();
        send(2'b10, 32'hFFFF_FFFF, 32'd2,         5'd4, 32'hFFFF_FFFF); wait_drain();
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000); wait_drain();
        send(2'b00, 32'hFFFF_FFFD, 32'd7,         5'd6, 32'hFFFF_FFEB); wait_drain();
        check_lat = 1'b0;

        // Four-op stream stalled by writeback.
        out_ready = 1'b0;
        send(2'b01, 32'hFFFF_FFF0, 32'd3,    5'd7, ref_mul(2'b01, 32'hFFFF_FFF0, 32'd3));
        send(2'b10, 32'h8000_0001, 32'hF0F0, 5'd8, ref_mul(2'b10, 32'h8000_0001, 32'hF0F0));
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            begin
                send(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9,  ref_mul(2'b00, 32'h1234_5678, 32'h9ABC_DEF0));
                send(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd10, ref_mul(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush with two ops in flight and a new op offered.
        out_ready = 1'b0;
        send(2'b00, 32'd11, 32'd12, 5'd20, ref_mul(2'b00, 32'd11, 32'd12));
        send(2'b00, 32'd13, 32'd14, 5'd21, ref_mul(2'b00, 32'd13, 32'd14));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd22;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 5'd23, ref_mul(2'b01, 32'h7FFF_FFFF, 32'h8000_0000));
        wait_drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(2'b11, 32'd100, 32'd200, 5'd24, ref_mul(2'b11, 32'd100, 32'd200));
        send(2'b11, 32'd300, 32'd400, 5'd25, ref_mul(2'b11, 32'd300, 32'd400));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, ref_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF));
        wait_drain();

        // Random traffic against random writeback backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [1:0]  op;
                    logic [31:0] a;
                    logic [31:0] b;
                    op = 2'($urandom_range(0, 3));
                    a  = $urandom();
                    b  = $urandom();
                    if (i % 8 == 0) a = 32'h8000_0000;
                    if (i % 5 == 0) b = 32'hFFFF_FFFF;
                    send(op, a, b, 5'(i), ref_mul(op, a, b));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
